i2c_wr_arbiter: RTL and testbench

Round-robin arbiter that shares one I2C24Wrt 24-bit write master among NREQ requesters, e.g. the CODEC power-up configuration sequencer and a runtime volume/mute controller. It latches the winning requester's 16-bit command, issues it to the master and waits for the master's completion handshake rather than a fixed delay. It retries NACKed or timed-out transfers and returns a per-requester done/err pulse. It sits between the requesters and the single I2C24Wrt instance driving SCL/SDA.

---
 rtl/i2c_wr_arbiter_pkg.sv | 18 +
 rtl/i2c_wr_arbiter_if.sv | 29 ++
 rtl/i2c_wr_arbiter_rr_pick.sv | 34 +++
 rtl/i2c_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_i2c_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_wr_arbiter_pkg.sv
// Shared types for the I2C write arbiter: FSM states and retry-gap sizing.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    GAP   = 3'd3,
    REL   = 3'd4
  } state_t;

  // Retry gap is 2**GAP_LOG2 cycles.
  localparam int GAP_LOG2 = 8;

  // Requester index width; covers up to 4 requesters.
  localparam int IDX_W = 2;

endpackage

// File: rtl/i2c_wr_arbiter_if.sv
// Requester and I2C24Wrt master-side signals of the write arbiter.
interface i2c_wr_arbiter_if #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]    req;
  logic [16*NREQ-1:0] cmd_in;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic               busy;
  logic [15:0]        m_data16;
  logic               m_wrt;
  logic               m_done;
  logic               m_err;

  // Arbiter side.
  modport slave (
    input  req, cmd_in, m_done, m_err,
    output gnt, done, err, busy, m_data16, m_wrt
  );

  // Requesters plus the write master.
  modport master (
    output req, cmd_in, m_done, m_err,
    input  gnt, done, err, busy, m_data16, m_wrt
  );

endinterface

// File: rtl/i2c_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching from last_owner+1 with wrap.
module rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [NREQ-1:0]  win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] pos;
  logic [NREQ-1:0]  pos_oh;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any_req = 1'b0;
    pos     = '0;
    pos_oh  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos    = IDX_W'((int'(last_owner) + k) % NREQ);
      pos_oh = NREQ'(1) << pos;
      if (!any_req && |(req & pos_oh)) begin
        any_req = 1'b1;
        win_oh  = pos_oh;
        win_idx = pos;
      end
    end
  end

endmodule

// File: rtl/i2c_wr_arbiter.sv
// Round-robin arbiter sharing one I2C24Wrt write master; issues the winner's command,
// waits for the master handshake, retries NACK/timeout with a gap, pulses done/err.
module i2c_wr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_RETRY = 3,
  parameter int TMO_W     = 18
) (
  input logic            clk,
  input logic            rst_n,
  i2c_wr_arbiter_if.slave bus
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_owner;
  logic [TMO_W-1:0] timer;
  logic [RTY_W-1:0] retry;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  done_q;
  logic [NREQ-1:0]  err_q;
  logic             busy_q;
  logic             m_wrt_q;
  logic [15:0]      m_data16_q;

  logic [NREQ-1:0]  win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic             xfer_fail;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (bus.req),
    .last_owner (last_owner),
    .win_oh     (win_oh),
    .win_idx    (win_idx),
    .any_req    (any_req)
  );

  // A completion in the timeout cycle counts as a completion, not a timeout.
  assign xfer_fail = bus.m_done ? bus.m_err : (timer == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NREQ - 1);
      timer      <= '0;
      retry      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      m_wrt_q    <= 1'b0;
      m_data16_q <= '0;
    end else begin
      m_wrt_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= win_idx;
            m_data16_q <= 16'(bus.cmd_in >> (16 * int'(win_idx)));
            retry      <= '0;
            gnt_q      <= win_oh;
            busy_q     <= 1'b1;
            m_wrt_q    <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (bus.m_done && !bus.m_err) begin
            done_q     <= gnt_q;
            last_owner <= owner;
            state      <= REL;
          end else if (xfer_fail) begin
            if (int'(retry) < MAX_RETRY) begin
              retry <= retry + 1'b1;
              timer <= '0;
              state <= GAP;
            end else begin
              err_q      <= gnt_q;
              last_owner <= owner;
              state      <= REL;
            end
          end
        end
        GAP: begin
          timer <= timer + 1'b1;
          if (timer[GAP_LOG2-1:0] == '1) begin
            m_wrt_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        REL: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.m_wrt    = m_wrt_q;
  assign bus.m_data16 = m_data16_q;

endmodule

// File: tb/tb_i2c_wr_arbiter.sv
// Directed bench for i2c_wr_arbiter with a behavioural I2C24Wrt master (ACK delay / NACK count / no reply).
module tb_i2c_wr_arbiter;

  logic clk;
  logic rst_n;

  i2c_wr_arbiter_if #(.NREQ(2)) bus ();

  i2c_wr_arbiter #(.NREQ(2), .MAX_RETRY(3), .TMO_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Master model state (written only by the model process).
  int cyc;
  int cnt_dn;
  int cur_idx;
  int nwrt;
  int ndone;
  int nerr;
  int done_cyc;
  int err_cyc;
  int mdone_cyc;
  int wrt_cyc [0:63];

  // Master model knobs (written only by the main sequence).
  int ack_dly;
  int never_ack;
  int nack_first;
  int wrt_base;

  initial begin
    cyc = 0; cnt_dn = 0; cur_idx = 0; nwrt = 0; ndone = 0; nerr = 0;
    done_cyc = 0; err_cyc = 0; mdone_cyc = 0;
    for (int i = 0; i < 64; i++) wrt_cyc[i] = 0;
    bus.m_done = 1'b0;
    bus.m_err  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.m_done = 1'b0;
      bus.m_err  = 1'b0;
      if (!rst_n) begin
        cnt_dn = 0;
      end else begin
        if (|bus.done) begin ndone++; done_cyc = cyc; end
        if (|bus.err)  begin nerr++;  err_cyc  = cyc; end
        if (cnt_dn > 0) begin
          cnt_dn--;
          if (cnt_dn == 0) begin
            bus.m_done = 1'b1;
            bus.m_err  = ((cur_idx - wrt_base) < nack_first);
            mdone_cyc  = cyc;
          end
        end
        if (bus.m_wrt) begin
          cur_idx = nwrt;
          if (nwrt < 64) wrt_cyc[nwrt] = cyc;
          nwrt++;
          if (never_ack == 0) cnt_dn = ack_dly;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_pulse(input int lim, input string tag);
    int k;
    k = 0;
    while (!(|bus.done || |bus.err) && k < lim) begin
      step();
      k++;
    end
    chk(tag, 32'(k < lim), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"},  32'(bus.gnt),      32'd0);
    chk({tag, "_busy"}, 32'(bus.busy),     32'd0);
    chk({tag, "_wrt"},  32'(bus.m_wrt),    32'd0);
    chk({tag, "_data"}, 32'(bus.m_data16), 32'd0);
    chk({tag, "_done"}, 32'(bus.done),     32'd0);
    chk({tag, "_err"},  32'(bus.err),      32'd0);
  endtask

  initial begin
    int b;
    int d;
    int own;
    n_chk = 0; n_pass = 0;
    ack_dly = 10; never_ack = 0; nack_first = 0; wrt_base = 0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.cmd_in = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check_idle_outputs("reset");

    // Single requester, ACK after 1000 cycles.
    ack_dly = 1000;
    bus.cmd_in[15:0] = 16'h0105;
    bus.req = 2'b01;
    step();
    chk("t1_gnt",  32'(bus.gnt),      32'h1);
    chk("t1_busy", 32'(bus.busy),     32'h1);
    chk("t1_wrt",  32'(bus.m_wrt),    32'h1);
    chk("t1_data", 32'(bus.m_data16), 32'h0105);
    wait_pulse(3000, "t1_wait");
    chk("t1_done",    32'(bus.done), 32'h1);
    chk("t1_err",     32'(bus.err),  32'h0);
    chk("t1_latency", 32'(done_cyc - mdone_cyc), 32'd1);
    chk("t1_nwrt",    32'(nwrt), 32'd1);
    bus.req = 2'b00;
    step();
    chk("t1_busy_off", 32'(bus.busy), 32'h0);
    chk("t1_gnt_off",  32'(bus.gnt),  32'h0);

    // Two requesters from reset, re-requesting continuously: 0,1,0,1.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ack_dly = 5;
    bus.cmd_in = {16'hB111, 16'hA000};
    bus.req = 2'b11;
    for (int s = 0; s < 4; s++) begin
      wait_pulse(200, "t2_wait");
      own = bus.done[1] ? 1 : 0;
      chk("t2_order", 32'(own), 32'(s % 2));
      chk("t2_data",  32'(bus.m_data16), (s % 2 == 0) ? 32'hA000 : 32'hB111);
      if (s == 3) bus.req = 2'b00;
      else        bus.req[own] = 1'b0;
      step();
      if (s != 3) bus.req[own] = 1'b1;
    end
    step();
    chk("t2_idle", 32'(bus.busy), 32'h0);

    // Two NACKs then ACK: three issues spaced by 10 + 256 + 1 cycles.
    wrt_base = nwrt;
    nack_first = 2;
    ack_dly = 10;
    bus.cmd_in[15:0] = 16'h0203;
    bus.req = 2'b01;
    wait_pulse(2000, "t3_wait");
    b = wrt_base;
    chk("t3_done", 32'(bus.done), 32'h1);
    chk("t3_err",  32'(bus.err),  32'h0);
    chk("t3_nwrt", 32'(nwrt - b), 32'd3);
    chk("t3_gap1", 32'(wrt_cyc[b+1] - wrt_cyc[b]),   32'd267);
    chk("t3_gap2", 32'(wrt_cyc[b+2] - wrt_cyc[b+1]), 32'd267);
    bus.req = 2'b00;
    step();

    // Always NACK: 1 + MAX_RETRY issues, then err.
    wrt_base = nwrt;
    nack_first = 100;
    bus.cmd_in[31:16] = 16'h0304;
    bus.req = 2'b10;
    wait_pulse(3000, "t4_wait");
    chk("t4_err",   32'(bus.err),  32'h2);
    chk("t4_done",  32'(bus.done), 32'h0);
    chk("t4_gnt",   32'(bus.gnt),  32'h2);
    chk("t4_busy",  32'(bus.busy), 32'h1);
    chk("t4_nwrt",  32'(nwrt - wrt_base), 32'd4);
    chk("t4_data",  32'(bus.m_data16), 32'h0304);
    bus.req = 2'b00;
    step();
    chk("t4_busy_off", 32'(bus.busy), 32'h0);
    chk("t4_gnt_off",  32'(bus.gnt),  32'h0);

    // No reply at all: timeout (~1023 WAIT cycles) handled as NACK.
    wrt_base = nwrt;
    nack_first = 0;
    never_ack = 1;
    bus.cmd_in[15:0] = 16'h0405;
    bus.req = 2'b01;
    wait_pulse(8000, "t5_wait");
    b = wrt_base;
    chk("t5_err",  32'(bus.err),  32'h1);
    chk("t5_done", 32'(bus.done), 32'h0);
    chk("t5_nwrt", 32'(nwrt - b), 32'd4);
    d = wrt_cyc[b+1] - wrt_cyc[b];
    chk("t5_retry_spacing", 32'(d >= 1279 && d <= 1282), 32'd1);
    d = err_cyc - wrt_cyc[b+3];
    chk("t5_err_delay", 32'(d >= 1023 && d <= 1026), 32'd1);
    bus.req = 2'b00;
    step();

    // Reset mid-WAIT, then requester 0 wins first.
    bus.cmd_in = {16'h0506, 16'h0607};
    bus.req = 2'b10;
    repeat (6) step();
    chk("t6_pre_busy", 32'(bus.busy), 32'h1);
    chk("t6_pre_gnt",  32'(bus.gnt),  32'h2);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_rst");
    step();
    rst_n = 1'b1;
    never_ack = 0;
    ack_dly = 5;
    bus.req = 2'b11;
    step();
    chk("t6_gnt",  32'(bus.gnt),      32'h1);
    chk("t6_data", 32'(bus.m_data16), 32'h0607);
    wait_pulse(200, "t6_wait");
    chk("t6_done", 32'(bus.done), 32'h1);
    bus.req = 2'b00;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
